beat_track_recorder: RTL and testbench
======================================

Name: beat_track_recorder

Overview:
Synthesizable multi-channel run-length recorder/player for the beat recorder.
- Record mode: samples a key code on every time-base tick and compresses it into (key, duration) entries in per-channel on-chip memory.
- Play mode: replays a channel's entries as a key stream with the recorded durations.
- Sits between the keyboard ASCII decoder and the buzzer/tone drivers. Replaces file-based record/readback with hardware storage.

Parameters:
- KEY_W, 7: key code width (ASCII).
- DUR_W, 16: run-duration field width, in ticks.
- DEPTH, 256: entries per channel; power of two.
- CHANNELS, 2: number of independent tracks (A, B, ...).

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- tick, input, 1: time-base strobe. One-cycle pulses, spaced at least 3 clk cycles apart.
- chan, input, clog2(CHANNELS): track select; latched at start_rec/start_play.
- start_rec, input, 1: pulse; begin recording chan.
- start_play, input, 1: pulse; begin playback of chan.
- stop, input, 1: pulse; end the current operation.
- ascii_in, input, KEY_W: live key code; 0 = no key.
- key_out, output, KEY_W: playback key.
- key_valid, output, 1: key_out is valid.
- rec_busy, output, 1: recording.
- play_busy, output, 1: playing.
- full, output, 1: the last recording hit DEPTH.
- done, output, 1: one-cycle pulse at end of playback.
- entry_count, output, clog2(DEPTH)+1: stored entries of the currently latched channel.

Behaviour:
- Reset (async): state IDLE. key_out=0, key_valid=0, rec_busy=0, play_busy=0, full=0, done=0. All channel lengths=0. Memory contents are not cleared; they are unreachable because lengths are 0.
- States: IDLE, REC, PFETCH, PLOAD, PRUN.
- IDLE:
  - start_rec wins over start_play if both are asserted.
  - start_rec: latch chan, length[chan]<=0, full<=0, run_key<=ascii_in, run_dur<=0, go to REC.
  - start_play with length[chan]==0: done pulse next cycle, stay IDLE.
  - start_play otherwise: idx<=0, go to PFETCH.
  - stop in IDLE: ignored.
- REC (rec_busy=1), on each tick:
  - ascii_in==run_key and run_dur<MAX (MAX = 2^DUR_W-1): run_dur+1.
  - ascii_in==run_key and run_dur==MAX: write {run_key,MAX}, run_dur<=1. A saturated run is split, never dropped.
  - ascii_in!=run_key: write {run_key,run_dur} if run_dur!=0, then run_key<=ascii_in, run_dur<=1.
- Writes: each write stores at address length[chan], then length+1. When length reaches DEPTH: full<=1, go to IDLE, and the in-progress run is discarded.
- stop in REC: write the pending run if run_dur!=0 and not full, then go to IDLE. If stop and tick arrive in the same cycle, stop wins and that tick is not counted.
- start_rec/start_play during REC or play: ignored.
- Key 0 (silence) is recorded like any other key.
- Play (play_busy=1):
  - PFETCH: drive read address idx; synchronous memory, 1-cycle read latency.
  - PLOAD: key_out<=entry.key, remaining<=entry.dur, key_valid<=1.
  - PRUN: on each tick, remaining-1. When remaining==1 at a tick: idx+1. If idx+1==length, end of track; otherwise go to PFETCH.
  - key_out/key_valid are held through PFETCH/PLOAD between entries, so there are no output gaps. The tick spacing rule guarantees no tick falls inside a fetch.
- End of track: key_valid<=0, key_out<=0, done pulse, go to IDLE.
- stop during play: next cycle key_valid=0, key_out=0, IDLE, no done pulse.
- entry_count always shows length[latched chan]. Channels never disturb each other.
- Reset asserted mid-operation: immediate return to reset values; the partial recording is lost.

Optional Feature:
BEAT_TRACK_LOOP_EN
- Defined: at end of track, idx wraps to 0 and playback continues (PFETCH). No done pulse, key_valid stays 1. Only stop or reset ends playback.
- Undefined: playback ends once as described above.

Test Plan:
Parameters: KEY_W=7, DUR_W=4, DEPTH=4, CHANNELS=2, tick every 4 clk.
1. Record, chan=0: ascii 97 for 3 ticks, then 98 for 2 ticks, then stop -> memory {97,3},{98,2}; entry_count=2; full=0.
2. Play chan=0 after scenario 1 -> key_out=97 valid for 3 ticks, then 98 for 2 ticks, then key_valid=0 and exactly one done pulse.
3. Record: hold 97 for 20 ticks, then stop -> entries {97,15},{97,5}; entry_count=2.
4. Record: keys 1,2,3,4,5,6, one tick each -> after the 4th write full=1, rec_busy=0, entry_count=4; key 5 is not stored.
5. Record chan=1 as {65,2}, then play chan=0 -> chan0 output unchanged from scenario 2. start_play on an empty channel -> done within 1 cycle, key_valid stays 0.
6. Assert reset mid-REC and mid-PRUN -> all outputs 0 immediately, entry_count=0. With BEAT_TRACK_LOOP_EN, scenario 2 repeats 97,98,97,... with no done pulse until stop.

Source files
------------

// File: rtl/beat_track_recorder.sv
// Multi-channel run-length key recorder/player: records (key, duration) runs per tick, replays them.
// Optional BEAT_TRACK_LOOP_EN: playback wraps to entry 0 at end of track instead of finishing.
module beat_track_recorder #(
  parameter int KEY_W    = 7,
  parameter int DUR_W    = 16,
  parameter int DEPTH    = 256,
  parameter int CHANNELS = 2
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           tick,
  input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] chan,
  input  logic                                           start_rec,
  input  logic                                           start_play,
  input  logic                                           stop,
  input  logic [KEY_W-1:0]                               ascii_in,
  output logic [KEY_W-1:0]                               key_out,
  output logic                                           key_valid,
  output logic                                           rec_busy,
  output logic                                           play_busy,
  output logic                                           full,
  output logic                                           done,
  output logic [$clog2(DEPTH):0]                         entry_count
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = KEY_W + DUR_W;
  localparam logic [DUR_W-1:0] DMAX  = '1;
  localparam logic [LW-1:0]    LFULL = LW'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_REC, S_PFETCH, S_PLOAD, S_PRUN} state_t;

  state_t                       r_state;
  logic [CW-1:0]                r_ch;
  logic [CHANNELS-1:0][LW-1:0]  r_len;
  logic [KEY_W-1:0]             r_key;
  logic [DUR_W-1:0]             r_dur;
  logic [DUR_W-1:0]             r_rem;
  logic [AW-1:0]                r_idx;
  logic [KEY_W-1:0]             r_key_out;
  logic                         r_valid;
  logic                         r_rec_busy;
  logic                         r_play_busy;
  logic                         r_full;
  logic                         r_done;
  logic [EW-1:0]                r_mem [CHANNELS][DEPTH];
  logic [EW-1:0]                r_rdata;

  logic [LW-1:0] w_len;
  logic [LW-1:0] w_len_inc;
  logic          w_wr_full;
  logic          w_same;
  logic          w_dmax;
  logic          w_we;
  logic          w_idx_last;

  assign w_len      = r_len[r_ch];
  assign w_len_inc  = w_len + 1'b1;
  assign w_wr_full  = (w_len_inc == LFULL);
  assign w_same     = (ascii_in == r_key);
  assign w_dmax     = (r_dur == DMAX);
  assign w_idx_last = (({1'b0, r_idx} + 1'b1) == w_len);
  // A run is closed on stop, on a key change, or when its duration saturates (split, not dropped).
  assign w_we = (r_state == S_REC) && (r_dur != '0) &&
                (stop || (tick && (!w_same || w_dmax)));

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_ch][w_len[AW-1:0]] <= {r_key, r_dur};
    r_rdata <= r_mem[r_ch][r_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_len       <= '0;
      r_key       <= '0;
      r_dur       <= '0;
      r_rem       <= '0;
      r_idx       <= '0;
      r_key_out   <= '0;
      r_valid     <= 1'b0;
      r_rec_busy  <= 1'b0;
      r_play_busy <= 1'b0;
      r_full      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_play_busy && stop) begin
        r_valid     <= 1'b0;
        r_key_out   <= '0;
        r_play_busy <= 1'b0;
        r_state     <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_rec) begin
              r_ch        <= chan;
              r_len[chan] <= '0;
              r_full      <= 1'b0;
              r_key       <= ascii_in;
              r_dur       <= '0;
              r_rec_busy  <= 1'b1;
              r_state     <= S_REC;
            end else if (start_play) begin
              r_ch <= chan;
              if (r_len[chan] == '0) begin
                r_done <= 1'b1;
              end else begin
                r_idx       <= '0;
                r_play_busy <= 1'b1;
                r_state     <= S_PFETCH;
              end
            end
          end
          S_REC: begin
            if (w_we) r_len[r_ch] <= w_len_inc;
            if (w_we && w_wr_full) r_full <= 1'b1;
            // Hitting DEPTH ends recording; the run in progress is discarded.
            if (stop || (w_we && w_wr_full)) begin
              r_rec_busy <= 1'b0;
              r_state    <= S_IDLE;
            end else if (tick) begin
              if (w_same && !w_dmax) begin
                r_dur <= r_dur + 1'b1;
              end else begin
                r_dur <= DUR_W'(1);
                r_key <= ascii_in;
              end
            end
          end
          S_PFETCH: r_state <= S_PLOAD;
          S_PLOAD: begin
            r_key_out <= r_rdata[EW-1:DUR_W];
            r_rem     <= r_rdata[DUR_W-1:0];
            r_valid   <= 1'b1;
            r_state   <= S_PRUN;
          end
          S_PRUN: begin
            if (tick) begin
              if (r_rem == DUR_W'(1)) begin
                if (w_idx_last) begin
`ifdef BEAT_TRACK_LOOP_EN
                  r_idx   <= '0;
                  r_state <= S_PFETCH;
`else
                  r_valid     <= 1'b0;
                  r_key_out   <= '0;
                  r_done      <= 1'b1;
                  r_play_busy <= 1'b0;
                  r_state     <= S_IDLE;
`endif
                end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_PFETCH;
                end
              end else begin
                r_rem <= r_rem - 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign key_out     = r_key_out;
  assign key_valid   = r_valid;
  assign rec_busy    = r_rec_busy;
  assign play_busy   = r_play_busy;
  assign full        = r_full;
  assign done        = r_done;
  assign entry_count = w_len;
endmodule

// File: tb/tb_beat_track_recorder.sv
// Scoreboard bench for beat_track_recorder: run-length reference model, per-tick key stream checking.
module tb_beat_track_recorder;
  localparam int KEY_W = 7, DUR_W = 4, DEPTH = 4, CHANNELS = 2;
  localparam int DMAXI = 15;
  localparam int DONE_EV = 1000;

  logic             clk = 1'b0;
  logic             reset, tick, start_rec, start_play, stop;
  logic [0:0]       chan;
  logic [KEY_W-1:0] ascii_in;
  logic [KEY_W-1:0] key_out;
  logic             key_valid, rec_busy, play_busy, full, done;
  logic [2:0]       entry_count;

  beat_track_recorder #(.KEY_W(KEY_W), .DUR_W(DUR_W), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .chan(chan), .start_rec(start_rec),
    .start_play(start_play), .stop(stop), .ascii_in(ascii_in), .key_out(key_out),
    .key_valid(key_valid), .rec_busy(rec_busy), .play_busy(play_busy), .full(full),
    .done(done), .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int exp_q[$];
  int rk[$];
  int mk[CHANNELS][DEPTH];
  int md[CHANNELS][DEPTH];
  int mlen[CHANNELS];

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic mon(input string nm, input int act);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got %0d expected nothing", nm, act);
    end else begin
      int e;
      e = exp_q.pop_front();
      chk(nm, act, e);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (tick && key_valid) mon("play_key", int'(key_out));
      if (done) mon("done_pulse", DONE_EV);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1; cyc();
    tick = 1'b0; cyc(); cyc(); cyc();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_key_out"}, int'(key_out), 0);
    chk({tag, "_key_valid"}, int'(key_valid), 0);
    chk({tag, "_rec_busy"}, int'(rec_busy), 0);
    chk({tag, "_play_busy"}, int'(play_busy), 0);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_entry_count"}, int'(entry_count), 0);
  endtask

  // Records rk (one key per tick) on channel ch; model = run-length encode, 15-tick cap, DEPTH limit.
  task automatic record(input int ch);
    int ek[$];
    int ed[$];
    int n;
    foreach (rk[i]) begin
      if (ek.size() > 0 && ek[ek.size()-1] == rk[i] && ed[ed.size()-1] < DMAXI)
        ed[ed.size()-1] = ed[ed.size()-1] + 1;
      else begin
        ek.push_back(rk[i]);
        ed.push_back(1);
      end
    end
    chan = 1'(ch);
    ascii_in = 7'($urandom_range(0, 127));
    start_rec = 1'b1; cyc();
    start_rec = 1'b0;
    foreach (rk[i]) begin
      ascii_in = 7'(rk[i]);
      do_tick();
    end
    chk("rec_busy_before_stop", int'(rec_busy), (ek.size() <= DEPTH) ? 1 : 0);
    stop = 1'b1; cyc();
    stop = 1'b0;
    n = (ek.size() < DEPTH) ? ek.size() : DEPTH;
    mlen[ch] = n;
    for (int i = 0; i < n; i++) begin
      mk[ch][i] = ek[i];
      md[ch][i] = ed[i];
    end
    chk("rec_entry_count", int'(entry_count), n);
    chk("rec_full", int'(full), (ek.size() >= DEPTH) ? 1 : 0);
    chk("rec_busy_after_stop", int'(rec_busy), 0);
  endtask

  // Plays channel ch; stop_after>0 stops after that many ticks, 0 runs to the natural end.
  task automatic play(input int ch, input int stop_after);
    int seq[$];
    int run;
    bit looping;
`ifdef BEAT_TRACK_LOOP_EN
    looping = 1'b1;
`else
    looping = 1'b0;
`endif
    for (int i = 0; i < mlen[ch]; i++)
      for (int j = 0; j < md[ch][i]; j++) seq.push_back(mk[ch][i]);
    chan = 1'(ch);
    if (seq.size() == 0) begin
      exp_q.push_back(DONE_EV);
      start_play = 1'b1; cyc();
      start_play = 1'b0;
      chk("empty_done", int'(done), 1);
      chk("empty_key_valid", int'(key_valid), 0);
      cyc();
      chk("empty_done_one_cycle", int'(done), 0);
      chk("empty_entry_count", int'(entry_count), 0);
    end else begin
      run = (stop_after > 0) ? stop_after : (looping ? 2 * seq.size() : seq.size());
      for (int i = 0; i < run; i++) exp_q.push_back(seq[i % seq.size()]);
      if (!looping && run == seq.size()) exp_q.push_back(DONE_EV);
      start_play = 1'b1; cyc();
      start_play = 1'b0; cyc(); cyc();
      chk("play_busy_start", int'(play_busy), 1);
      chk("play_first_valid", int'(key_valid), 1);
      chk("play_first_key", int'(key_out), seq[0]);
      chk("play_entry_count", int'(entry_count), mlen[ch]);
      repeat (run) do_tick();
      stop = 1'b1; cyc();
      stop = 1'b0;
      chk("play_end_valid", int'(key_valid), 0);
      chk("play_end_key", int'(key_out), 0);
      chk("play_end_busy", int'(play_busy), 0);
    end
    cyc();
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic clear_model();
    for (int c = 0; c < CHANNELS; c++) mlen[c] = 0;
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int prev, n, sa;
    reset = 1'b1; tick = 1'b0; chan = 1'b0; start_rec = 1'b0; start_play = 1'b0;
    stop = 1'b0; ascii_in = '0;
    clear_model();
    cyc(); cyc();
    chk_zero("reset");
    reset = 1'b0; cyc();

    play(0, 0);                                   // empty channel
    rk = '{97, 97, 97, 98, 98}; record(0);        // {97,3},{98,2}
    play(0, 0);
    rk = '{65, 65}; record(1);                    // other channel must not disturb ch0
    play(0, 0);
    play(1, 0);
    rk.delete(); repeat (20) rk.push_back(97); record(0);   // {97,15},{97,5}
    play(0, 0);
    rk = '{1, 2, 3, 4, 5, 6}; record(0);          // fills at 4 entries
    play(0, 0);
    play(0, 2);                                   // stop mid-play
    rk.delete(); repeat (30) rk.push_back(0); record(1);    // silence, exact saturation split
    play(1, 0);

    for (int it = 0; it < 40; it++) begin
      rk.delete();
      n = $urandom_range(0, 24);
      prev = 97;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) < 3) prev = (prev == 0) ? 97 : ($urandom_range(0, 3) == 0 ? 0 : 96 + $urandom_range(1, 3));
        rk.push_back(prev);
      end
      record($urandom_range(0, 1));
      n = $urandom_range(0, 1);
      sa = 0;
      if (mlen[n] > 0 && $urandom_range(0, 3) == 0) sa = $urandom_range(1, md[n][0]);
      play(n, sa);
    end

    // reset during recording
    chan = 1'b0; ascii_in = 7'd50;
    start_rec = 1'b1; cyc(); start_rec = 1'b0;
    do_tick(); ascii_in = 7'd51; do_tick();
    reset = 1'b1; #1;
    chk("rst_rec_busy_now", int'(rec_busy), 0);
    chk_zero("rst_mid_rec");
    clear_model();
    cyc(); reset = 1'b0; cyc();

    // reset during playback
    rk = '{97, 97, 97}; record(1);
    chan = 1'b1;
    exp_q.push_back(97);
    start_play = 1'b1; cyc(); start_play = 1'b0; cyc(); cyc();
    do_tick();
    chk("prerst_key_valid", int'(key_valid), 1);
    reset = 1'b1; #1;
    chk_zero("rst_mid_play");
    chk("rst_play_drained", exp_q.size(), 0);
    clear_model();
    cyc(); reset = 1'b0; cyc();
    play(1, 0);
    play(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
